// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and
// the legal range of the WIDTH parameter.
package gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } clkdiv_state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkinv_func.sv
// Functional model of a clock inverter cell used as the output polarity stage.
module gf180mcu_fd_sc_mcu9t5v0__clkinv_func (
  input  logic I,
  output logic ZN
);

  assign ZN = ~I;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// Programmable 50%-duty clock divider (period 2*(div+1)) with glitch-free
// stop, divisor changes deferred to the falling boundary, and ACK/TICK pulses.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int INVERT    = 1,
  parameter int RESET_DIV = 0
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             ZN,
  output logic             TICK,
  output logic             ACK,
  output logic             ACTIVE
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("clkdiv_prog: WIDTH out of range");
  end

  clkdiv_state_e    state_q, state_d;
  logic             q_q, q_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_r_q, div_r_d;
  logic [WIDTH-1:0] div_p_q, div_p_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             wrap;
  logic             commit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_STOP;
      q_q     <= 1'b0;
      cnt_q   <= '0;
      div_r_q <= WIDTH'(RESET_DIV);
      div_p_q <= '0;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      div_r_q <= div_r_d;
      div_p_q <= div_p_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    div_r_d = div_r_q;
    div_p_d = div_p_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    commit  = 1'b0;
    wrap    = (cnt_q == div_r_q);

    case (state_q)
      ST_STOP: begin
        q_d   = 1'b0;
        cnt_d = '0;
        if (LOAD) begin
          div_r_d = DIV;
          ack_d   = 1'b1;
        end
        if (EN) begin
          state_d = ST_RUN;
          q_d     = 1'b1;
          tick_d  = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (!EN && !q_q) begin
          // Low phase already: stopping here cannot shorten a high phase.
          state_d = ST_STOP;
          q_d     = 1'b0;
          cnt_d   = '0;
          commit  = 1'b1;
        end else if (wrap) begin
          cnt_d  = '0;
          q_d    = ~q_q;
          tick_d = ~q_q;
          if (q_q) begin
            commit  = 1'b1;
            state_d = EN ? ST_RUN : ST_STOP;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
          state_d = EN ? ST_RUN : ST_DRAIN;
        end

        // Divisor updates only land on a falling boundary or entry to STOP.
        if (commit) begin
          if (LOAD) begin
            div_r_d = DIV;
            ack_d   = 1'b1;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            div_r_d = div_p_q;
            ack_d   = 1'b1;
            pend_d  = 1'b0;
          end
        end else if (LOAD) begin
          div_p_d = DIV;
          pend_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_STOP;
        q_d     = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign TICK   = tick_q;
  assign ACK    = ack_q;
  assign ACTIVE = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  if (INVERT != 0) begin : g_inv
    gf180mcu_fd_sc_mcu9t5v0__clkinv_func u_inv (
      .I  (q_q),
      .ZN (ZN)
    );
  end else begin : g_buf
    assign ZN = q_q;
  end

`ifndef FUNCTIONAL
  specify
    (CLK => ZN) = (0, 0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// Bench for the programmable clock divider: directed scenarios plus random
// stimulus, compared each cycle against a remaining-cycles phase model.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog;

  localparam int W = 4;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] div;
  logic         zn, tick, ack, active;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog #(
    .WIDTH     (W),
    .INVERT    (1),
    .RESET_DIV (0)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .EN     (en),
    .DIV    (div),
    .LOAD   (load),
    .ZN     (zn),
    .TICK   (tick),
    .ACK    (ack),
    .ACTIVE (active)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: level plus cycles remaining in the current phase.
  bit m_run, m_lvl, m_tick, m_ack, m_pend;
  int m_left, m_div, m_pval;

  // Scoreboard of per-cycle expected outputs {zn, tick, ack, active}.
  logic [3:0] exp_q[$];

  function automatic void model_step(input bit r, input bit e, input bit l, input int d);
    bit bnd, stop;
    if (r) begin
      m_run = 0; m_lvl = 0; m_left = 0; m_div = 0;
      m_pend = 0; m_pval = 0; m_tick = 0; m_ack = 0;
      return;
    end
    m_tick = 0;
    m_ack  = 0;
    if (!m_run) begin
      if (l) begin m_div = d; m_ack = 1; end
      if (e) begin m_run = 1; m_lvl = 1; m_left = m_div + 1; m_tick = 1; end
      return;
    end
    bnd  = 0;
    stop = 0;
    if (!e && !m_lvl) begin
      bnd = 1; stop = 1;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_lvl) begin
          m_lvl = 0; bnd = 1; stop = !e;
        end else begin
          m_lvl = 1; m_tick = 1; m_left = m_div + 1;
        end
      end
    end
    if (bnd) begin
      if (l) begin m_div = d; m_ack = 1; m_pend = 0; end
      else if (m_pend) begin m_div = m_pval; m_ack = 1; m_pend = 0; end
      if (stop) begin m_run = 0; m_lvl = 0; end
      else m_left = m_div + 1;
    end else if (l) begin
      m_pval = d; m_pend = 1;
    end
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs, advance model, compare after the edge.
  task automatic cyc(input bit r, input bit e, input bit l, input int d);
    logic [3:0] exp_v;
    rst  = r;
    en   = e;
    load = l;
    div  = W'(d);
    @(posedge clk);
    model_step(r, e, l, d);
    exp_q.push_back({~m_lvl, m_tick, m_ack, m_run});
    #1;
    exp_v = exp_q.pop_front();
    check("ZN", zn, exp_v[3]);
    check("TICK", tick, exp_v[2]);
    check("ACK", ack, exp_v[1]);
    check("ACTIVE", active, exp_v[0]);
  endtask

  // Run until the model sits in the second cycle of a high phase (bounded).
  task automatic wait_hi1();
    for (int i = 0; i < 64 && !(m_run && m_lvl && m_left == m_div); i++)
      cyc(0, 1, 0, 0);
    check_int("WAIT_HI1", int'(m_run && m_lvl && m_left == m_div), 1);
  endtask

  int ticks, highs, acks, last;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; div = '0;
    model_step(1, 0, 0, 0);

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("RST_ZN", zn, 1'b1);
    check("RST_ACTIVE", active, 1'b0);

    // Divide by 2 right out of reset
    ticks = 0;
    repeat (8) begin cyc(0, 1, 0, 0); ticks += int'(tick); end
    check_int("DIV0_TICKS", ticks, 4);

    // Load 3 while stopped, then run: period 8
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 3);
    check("STOP_LOAD_ACK", ack, 1'b1);
    cyc(0, 1, 0, 0);
    ticks = 0; highs = 0;
    repeat (16) begin
      cyc(0, 1, 0, 0);
      ticks += int'(tick);
      highs += int'(zn == 1'b0);
    end
    check_int("DIV3_TICKS", ticks, 2);
    check_int("DIV3_HIGHS", highs, 8);

    // Change to 1 mid high phase: ack at fall, then period 4
    wait_hi1();
    cyc(0, 1, 1, 1);
    acks = 0;
    repeat (20) begin cyc(0, 1, 0, 0); acks += int'(ack); end
    check_int("RELOAD_ACKS", acks, 1);

    // Back to 3, then drop EN early in a high phase
    cyc(0, 1, 1, 3);
    repeat (12) cyc(0, 1, 0, 0);
    wait_hi1();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("DRAIN_ACTIVE", active, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("DRAIN_DONE_ZN", zn, 1'b1);
    check("DRAIN_DONE_ACTIVE", active, 1'b0);

    // Two loads in one high phase: one ack, last value wins
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 1, 2);
    acks = 0;
    repeat (24) begin cyc(0, 1, 0, 0); acks += int'(ack); end
    check_int("DOUBLE_LOAD_ACKS", acks, 1);
    check_int("DOUBLE_LOAD_DIV", m_div, 2);

    // Widest divisor: period 32
    repeat (10) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 15);
    highs = 0;
    repeat (64) begin cyc(0, 1, 0, 0); highs += int'(zn == 1'b0); end
    check_int("DIV15_HIGHS", highs, 32);

    // Reset with a pending divisor
    cyc(0, 1, 1, 7);
    cyc(1, 1, 0, 0);
    check("RSTPEND_ACK", ack, 1'b0);
    check("RSTPEND_ZN", zn, 1'b1);
    acks = 0;
    repeat (6) begin cyc(0, 1, 0, 0); acks += int'(ack); end
    check_int("RSTPEND_LATE_ACKS", acks, 0);

    // Random stimulus
    last = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) last = ~last & 1;
      cyc(($urandom_range(0, 99) == 0), bit'(last),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2**W - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.md
GF180MCU_FD_SC_MCU9T5V0__CLKDIV_PROG -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, width of divisor and phase counter (2..16).
REQ-002 SHALL provide parameter INVERT, default 1; 1 = ZN is the inverted divided clock, 0 = true polarity.
REQ-003 SHALL provide parameter RESET_DIV, default 0, divisor value loaded at reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset: CLK and RST, both inputs of width 1.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 EN  input  1  run request; 1 = run the divider, 0 = glitch-free stop.
REQ-008 DIV  input  WIDTH  requested divisor; divided period = 2*(DIV+1) CLK cycles, 50% duty.
REQ-009 LOAD  input  1  single-cycle strobe that captures DIV as the pending divisor.
REQ-010 ZN  output  1  divided clock, registered, polarity per INVERT.
REQ-011 TICK  output  1  one-cycle pulse, registered, in the first cycle of each internal high phase.
REQ-012 ACK  output  1  one-cycle pulse, registered, in the first cycle a newly loaded divisor is in effect.
REQ-013 ACTIVE  output  1  1 when the state is RUN or DRAIN.
REQ-014 Under USE_POWER_PINS, SHALL add VDD and VSS as inout ports.

Function
REQ-015 Internal divided clock q; ZN SHALL equal q XOR INVERT.
REQ-016 The FSM SHALL have three states. STOP: q=0, cnt=0. RUN: dividing. DRAIN: finishing the high phase after EN falls.
REQ-017 STOP->RUN when EN=1; next cycle q=1, cnt=0, TICK=1.
REQ-018 In RUN/DRAIN, cnt SHALL increment each cycle. When cnt==div_r: cnt<=0 and q<=~q. When q goes 0->1: TICK=1.
REQ-019 Each phase (high or low) SHALL last exactly div_r+1 cycles; no runt phase under any input sequence.
REQ-020 RUN with EN=0: if q=1, go to DRAIN; if q=0, go to STOP immediately.
REQ-021 DRAIN: on the falling toggle, go to STOP. If EN=1 during DRAIN, return to RUN with no phase disturbance.
REQ-022 LOAD in STOP SHALL set div_r<=DIV the next cycle, with ACK=1 that cycle.
REQ-023 LOAD in RUN/DRAIN SHALL set div_p<=DIV and pend=1. On the next 1->0 toggle of q: div_r<=div_p, pend<=0, ACK=1, and the new low phase uses the new div_r.
REQ-024 LOAD while pend=1 SHALL overwrite div_p; exactly one ACK is issued, for the last value.
REQ-025 LOAD in the same cycle as a 1->0 toggle SHALL apply DIV directly at that boundary, with ACK.
REQ-026 Transition to STOP with pend=1 SHALL commit div_p with ACK on entry to STOP.
REQ-027 DIV=0 SHALL give a period of 2 cycles. DIV=2^WIDTH-1 SHALL give a period of 2^(WIDTH+1) cycles; cnt never wraps past div_r.

Reset
REQ-028 RST=1 SHALL override all inputs. Next cycle: state=STOP, q=0, ZN=INVERT, cnt=0, div_r=RESET_DIV, div_p=0, pend=0, TICK=0, ACK=0, ACTIVE=0.
REQ-029 RST mid-phase SHALL truncate the phase immediately; a runt phase is permitted only at reset.

Structure
REQ-030 Package gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg SHALL hold the FSM state encoding (STOP=2'b00, RUN=2'b01, DRAIN=2'b10) and the WIDTH range limits.
REQ-031 The output polarity stage SHALL instantiate gf180mcu_fd_sc_mcu9t5v0__clkinv_func when INVERT=1, and a direct assign otherwise.
REQ-032 The block SHALL contain a specify block with arc CLK => ZN, guarded by `ifndef FUNCTIONAL.

Verification (WIDTH=4, INVERT=1, RESET_DIV=0)
REQ-033 RST 1 cycle, then EN=1 -> ZN toggles every cycle (period 2); TICK every second cycle; ACTIVE=1.
REQ-034 In STOP, LOAD with DIV=3 -> ACK next cycle; then EN=1 -> ZN low 4 cycles, high 4 cycles, period 8, one TICK per 8 cycles.
REQ-035 Running at DIV=3, LOAD DIV=1 at high-phase cnt=1 -> high phase still 4 cycles; ACK on the falling toggle of q; then period 4.
REQ-036 Running at DIV=3, EN=0 at high-phase cnt=1 -> q high 2 more cycles, then q=0, ACTIVE=0; no phase shorter than 4 cycles.
REQ-037 LOAD DIV=5, then LOAD DIV=2 within the same high phase -> single ACK at the falling edge; subsequent phases 3 cycles.
REQ-038 RST mid-run with pend=1 -> next cycle ZN=1, TICK=0, ACK=0, no later ACK; divisor back to 0.
